// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI receive path: status nibbles, the parser
// state encoding and the commit record passed from parser to voice allocator.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    D1,
    D2
  } parse_state_t;

  typedef struct packed {
    logic       is_on;
    logic [6:0] note;
    logic [6:0] vel;
  } commit_t;

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser for note-on/note-off on one channel, with running
// status. The commit is combinational from the velocity byte so the voice
// table can register its outputs on the same edge (1-cycle latency overall).
module midi_msg_parser
  import midi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic [3:0] channel,
  output logic       commit_valid,
  output commit_t    commit
);

  parse_state_t state;
  logic         rs_on;    // running status is note-on (else note-off)
  logic [6:0]   note_q;

  // Commit fires on the velocity byte; 0x9n with velocity 0 is a note-off.
  // NOTE: every output of a combinational block is given a default first so no latch is inferred.
  always_comb begin
    commit_valid = 1'b0;
    commit.note  = note_q;
    commit.vel   = byte_data[6:0];
    commit.is_on = rs_on && (byte_data[6:0] != 7'd0);
    if (byte_valid && !byte_data[7] && state == D2) begin
      commit_valid = 1'b1;
    end
  end

  // Parser FSM and running status; realtime bytes pass through untouched.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rs_on  <= 1'b0;
      note_q <= '0;
    end else if (byte_valid && byte_data < RT_MIN) begin
      if (byte_data[7]) begin
        if ((byte_data[7:4] == ST_NOTE_OFF || byte_data[7:4] == ST_NOTE_ON) &&
            byte_data[3:0] == channel) begin
          rs_on <= (byte_data[7:4] == ST_NOTE_ON);
          state <= D1;
        end else begin
          rs_on <= 1'b0;
          state <= IDLE;
        end
      end else begin
        case (state)
          D1: begin
            note_q <= byte_data[6:0];
            state  <= D2;
          end
          D2:      state <= D1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Voice allocator: parses the MIDI stream (via midi_msg_parser) and shares
// NUM_VOICES voices between note-on/note-off commands on one channel.
// Build option VOICE_STEAL_EN: when defined, a note-on with no free voice
// steals the oldest gated voice; otherwise the note is dropped and DROP pulses.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2,
  parameter int AGE_W      = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BYTE_VALID,
  input  logic [7:0]              BYTE_DATA,
  input  logic [3:0]              CHANNEL,
  output logic [NUM_VOICES-1:0]   VOICE_GATE,
  output logic [NUM_VOICES*7-1:0] VOICE_NOTE,
  output logic [NUM_VOICES*7-1:0] VOICE_VEL,
  output logic                    EVT_VALID,
  output logic [VIDX_W-1:0]       EVT_VOICE,
  output logic                    EVT_ON,
  output logic                    DROP,
  output logic [VIDX_W:0]         ACTIVE_CNT
);

  logic    commit_valid;
  commit_t commit;

  midi_msg_parser u_parser (
    .clk          (CLK),
    .reset        (RESET),
    .byte_valid   (BYTE_VALID),
    .byte_data    (BYTE_DATA),
    .channel      (CHANNEL),
    .commit_valid (commit_valid),
    .commit       (commit)
  );

  logic [NUM_VOICES-1:0] gate_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];

  logic                  hit, free, on_go, off_go, drop_next;
  logic [VIDX_W-1:0]     hit_idx, free_idx, on_idx;
  logic [NUM_VOICES-1:0] gate_next;
  logic [VIDX_W:0]       cnt_next;

  // Find the voice holding the note and the lowest-index free voice
  // (descending scan so the lowest index is written last).
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && note_q[i] == commit.note) begin
        hit     = 1'b1;
        hit_idx = VIDX_W'(i);
      end
      if (!gate_q[i]) begin
        free     = 1'b1;
        free_idx = VIDX_W'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  // Ages only steer stealing, so they exist only in the stealing build.
  logic [AGE_W-1:0]  age_q [NUM_VOICES];
  logic [AGE_W-1:0]  oldest;
  logic [VIDX_W-1:0] steal_idx;

  // Oldest gated voice; strict compare keeps the lowest index on ties.
  always_comb begin
    steal_idx = '0;
    oldest    = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > oldest) begin
        oldest    = age_q[i];
        steal_idx = VIDX_W'(i);
      end
    end
  end
`endif

  // Decide what the commit does: retrigger, allocate, steal/drop, or release.
  always_comb begin
    on_go     = 1'b0;
    off_go    = 1'b0;
    drop_next = 1'b0;
    on_idx    = hit_idx;
    if (commit_valid) begin
      if (commit.is_on) begin
        if (hit) begin
          on_go = 1'b1;
        end else if (free) begin
          on_go  = 1'b1;
          on_idx = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          on_go  = 1'b1;
          on_idx = steal_idx;
`else
          drop_next = 1'b1;
`endif
        end
      end else begin
        off_go = hit;
      end
    end
  end

  // Next gate vector and its popcount, so ACTIVE_CNT tracks VOICE_GATE exactly.
  always_comb begin
    gate_next = gate_q;
    if (on_go)  gate_next[on_idx]  = 1'b1;
    if (off_go) gate_next[hit_idx] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      cnt_next = cnt_next + (VIDX_W + 1)'(gate_next[i]);
    end
  end

  // Voice table and event outputs.
  // NOTE: note/velocity storage is reset too, because every output must read 0 after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gate_q     <= '0;
      ACTIVE_CNT <= '0;
      EVT_VALID  <= 1'b0;
      EVT_VOICE  <= '0;
      EVT_ON     <= 1'b0;
      DROP       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
    end else begin
      gate_q     <= gate_next;
      ACTIVE_CNT <= cnt_next;
      EVT_VALID  <= on_go || off_go;
      DROP       <= drop_next;
      if (on_go || off_go) begin
        EVT_VOICE <= on_idx;
        EVT_ON    <= on_go;
      end
      if (on_go) begin
        note_q[on_idx] <= commit.note;
        vel_q[on_idx]  <= commit.vel;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // Age counters: the triggered voice restarts, other gated voices age (saturating).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else if (on_go) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (VIDX_W'(i) == on_idx) begin
          age_q[i] <= '0;
        end else if (gate_q[i] && age_q[i] != AGE_MAX) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end
`endif

  // Pack the per-voice registers onto the flat output buses.
  always_comb begin
    VOICE_GATE = gate_q;
    VOICE_NOTE = '0;
    VOICE_VEL  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      VOICE_NOTE[7*i +: 7] = note_q[i];
      VOICE_VEL[7*i +: 7]  = vel_q[i];
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator (NUM_VOICES=4): directed byte
// table, hand-written fill/steal and reset sequences, then randomized traffic
// compared against a message-level reference model.
module tb_midi_voice_allocator;

  localparam int NV = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          BYTE_VALID = 1'b0;
  logic [7:0]    BYTE_DATA = 8'h00;
  logic [3:0]    CHANNEL = 4'h0;
  logic [NV-1:0] VOICE_GATE;
  logic [NV*7-1:0] VOICE_NOTE, VOICE_VEL;
  logic          EVT_VALID, EVT_ON, DROP;
  logic [1:0]    EVT_VOICE;
  logic [2:0]    ACTIVE_CNT;

  midi_voice_allocator #(.NUM_VOICES(NV), .VIDX_W(2), .AGE_W(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_DATA  (BYTE_DATA),
    .CHANNEL    (CHANNEL),
    .VOICE_GATE (VOICE_GATE),
    .VOICE_NOTE (VOICE_NOTE),
    .VOICE_VEL  (VOICE_VEL),
    .EVT_VALID  (EVT_VALID),
    .EVT_VOICE  (EVT_VOICE),
    .EVT_ON     (EVT_ON),
    .DROP       (DROP),
    .ACTIVE_CNT (ACTIVE_CNT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are then read at the next falling edge.
  task automatic drive(input logic v, input logic [7:0] d);
    BYTE_VALID = v;
    BYTE_DATA  = d;
    @(negedge CLK);
    BYTE_VALID = 1'b0;
  endtask

  task automatic do_reset();
    BYTE_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // ---------------- reference model (message level) ----------------
  int       m_rs;                // running status byte, -1 = none
  int       m_q[$];              // data bytes collected for the current message
  bit       m_gate [NV];
  int       m_note [NV];
  int       m_vel  [NV];
  int       m_stamp[NV];         // note-on commit count when the voice was triggered
  int       m_on_count;
  bit       e_evt, e_on, e_drop;
  int       e_voice;

  function automatic void model_reset();
    m_rs = -1;
    m_q.delete();
    m_on_count = 0;
    e_evt = 0; e_on = 0; e_drop = 0; e_voice = 0;
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = 0;
    end
  endfunction

  function automatic int model_age(int i);
    int a;
    a = m_on_count - m_stamp[i];
    return (a > 15) ? 15 : a;
  endfunction

  function automatic void model_commit(bit on, int n, int v);
    int k;
    k = -1;
    for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) k = i;
    if (!on) begin
      if (k >= 0) begin
        m_gate[k] = 0;
        e_evt = 1; e_on = 0; e_voice = k;
      end
      return;
    end
    if (k < 0) for (int i = NV - 1; i >= 0; i--) if (!m_gate[i]) k = i;
    if (k < 0) begin
`ifdef VOICE_STEAL_EN
      k = 0;
      for (int i = 1; i < NV; i++) if (model_age(i) > model_age(k)) k = i;
`else
      e_drop = 1;
      return;
`endif
    end
    m_on_count++;
    m_stamp[k] = m_on_count;
    m_gate[k] = 1; m_note[k] = n; m_vel[k] = v;
    e_evt = 1; e_on = 1; e_voice = k;
  endfunction

  function automatic void model_step(bit v, int d, int ch);
    e_evt = 0; e_drop = 0;
    if (!v || d >= 'hF8) return;
    if (d >= 'h80) begin
      if ((d / 16 == 8 || d / 16 == 9) && d % 16 == ch) m_rs = d;
      else m_rs = -1;
      m_q.delete();
      return;
    end
    if (m_rs < 0) return;
    m_q.push_back(d);
    if (m_q.size() == 2) begin
      model_commit(m_rs / 16 == 9 && m_q[1] != 0, m_q[0], m_q[1]);
      m_q.delete();
    end
  endfunction

  task automatic compare_model(input string tag);
    logic [NV-1:0]   g;
    logic [NV*7-1:0] n, vl;
    int              cnt;
    cnt = 0;
    for (int i = 0; i < NV; i++) begin
      g[i] = m_gate[i];
      n[7*i +: 7]  = 7'(m_note[i]);
      vl[7*i +: 7] = 7'(m_vel[i]);
      cnt += int'(m_gate[i]);
    end
    check({tag, " gate"}, 64'(VOICE_GATE), 64'(g));
    check({tag, " note"}, 64'(VOICE_NOTE), 64'(n));
    check({tag, " vel"},  64'(VOICE_VEL),  64'(vl));
    check({tag, " cnt"},  64'(ACTIVE_CNT), 64'(cnt));
    check({tag, " drop"}, 64'(DROP),       64'(e_drop));
    check({tag, " evt"},  64'(EVT_VALID),  64'(e_evt));
    if (e_evt) check({tag, " evt_id"}, {EVT_VOICE, EVT_ON}, {62'(e_voice), e_on});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] d;
    logic       evt;
    int         ev;
    logic       eon;
    logic [3:0] gate;
    int         cnt;
    logic [6:0] n0;
    logic [6:0] v0;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // 1. basic note-on
    tbl.push_back('{8'h90, 0, 0, 0, 4'b0000, 0, 7'h00, 7'h00});
    tbl.push_back('{8'h3C, 0, 0, 0, 4'b0000, 0, 7'h00, 7'h00});
    tbl.push_back('{8'h64, 1, 0, 1, 4'b0001, 1, 7'h3C, 7'h64});
    // 2. running status note-on, then note-off via vel 0
    tbl.push_back('{8'h40, 0, 0, 0, 4'b0001, 1, 7'h3C, 7'h64});
    tbl.push_back('{8'h50, 1, 1, 1, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'h3C, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'h00, 1, 0, 0, 4'b0010, 1, 7'h3C, 7'h64});
    // 3. other channel ignored, realtime mid-message, foreign status aborts
    tbl.push_back('{8'h91, 0, 0, 0, 4'b0010, 1, 7'h3C, 7'h64});
    tbl.push_back('{8'h3C, 0, 0, 0, 4'b0010, 1, 7'h3C, 7'h64});
    tbl.push_back('{8'h64, 0, 0, 0, 4'b0010, 1, 7'h3C, 7'h64});
    tbl.push_back('{8'h90, 0, 0, 0, 4'b0010, 1, 7'h3C, 7'h64});
    tbl.push_back('{8'h3C, 0, 0, 0, 4'b0010, 1, 7'h3C, 7'h64});
    tbl.push_back('{8'hF8, 0, 0, 0, 4'b0010, 1, 7'h3C, 7'h64});
    tbl.push_back('{8'h64, 1, 0, 1, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'h90, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'h3C, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'hB0, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'h64, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h64});
    // 5. retrigger held note with new velocity
    tbl.push_back('{8'h90, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'h3C, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h64});
    tbl.push_back('{8'h20, 1, 0, 1, 4'b0011, 2, 7'h3C, 7'h20});
    // 0x8n note-off releases voice1
    tbl.push_back('{8'h80, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h20});
    tbl.push_back('{8'h40, 0, 0, 0, 4'b0011, 2, 7'h3C, 7'h20});
    tbl.push_back('{8'h00, 1, 1, 0, 4'b0001, 1, 7'h3C, 7'h20});
  end

  initial begin
    logic [7:0] seq [];
    logic [7:0] d;
    int         ch;
    bit         v;

    @(negedge CLK);
    do_reset();

    // reset state
    check("reset gate", 64'(VOICE_GATE), 64'd0);
    check("reset cnt",  64'(ACTIVE_CNT), 64'd0);
    check("reset evt",  64'(EVT_VALID),  64'd0);

    // directed table
    for (int r = 0; r < tbl.size(); r++) begin
      drive(1'b1, tbl[r].d);
      check($sformatf("tbl%0d evt", r),  64'(EVT_VALID),       64'(tbl[r].evt));
      if (tbl[r].evt)
        check($sformatf("tbl%0d evt_id", r), {EVT_VOICE, EVT_ON}, {62'(tbl[r].ev), tbl[r].eon});
      check($sformatf("tbl%0d gate", r), 64'(VOICE_GATE),      64'(tbl[r].gate));
      check($sformatf("tbl%0d cnt", r),  64'(ACTIVE_CNT),      64'(tbl[r].cnt));
      check($sformatf("tbl%0d note0", r), 64'(VOICE_NOTE[6:0]), 64'(tbl[r].n0));
      check($sformatf("tbl%0d vel0", r), 64'(VOICE_VEL[6:0]),  64'(tbl[r].v0));
      check($sformatf("tbl%0d drop", r), 64'(DROP),            64'd0);
    end

    // 4. fill all voices, then one more note-on
    do_reset();
    seq = '{8'h90, 8'h3C, 8'h01, 8'h3E, 8'h01, 8'h40, 8'h01, 8'h41, 8'h01};
    foreach (seq[i]) drive(1'b1, seq[i]);
    check("fill gate", 64'(VOICE_GATE), 64'hF);
    check("fill cnt",  64'(ACTIVE_CNT), 64'd4);
    drive(1'b1, 8'h43);
    drive(1'b1, 8'h01);
`ifdef VOICE_STEAL_EN
    check("steal drop",   64'(DROP), 64'd0);
    check("steal evt",    64'(EVT_VALID), 64'd1);
    check("steal evt_id", {EVT_VOICE, EVT_ON}, {62'd0, 1'b1});
    check("steal note0",  64'(VOICE_NOTE[6:0]), 64'h43);
`else
    check("full drop",  64'(DROP), 64'd1);
    check("full evt",   64'(EVT_VALID), 64'd0);
    check("full note0", 64'(VOICE_NOTE[6:0]), 64'h3C);
`endif
    check("full gate", 64'(VOICE_GATE), 64'hF);
    drive(1'b0, 8'h00);
    check("drop pulse end", 64'(DROP), 64'd0);

    // 6. reset mid-message clears everything, then a lone data byte is ignored
    drive(1'b1, 8'h90);
    drive(1'b1, 8'h3C);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst gate", 64'(VOICE_GATE), 64'd0);
    check("rst note", 64'(VOICE_NOTE), 64'd0);
    check("rst vel",  64'(VOICE_VEL),  64'd0);
    check("rst cnt",  64'(ACTIVE_CNT), 64'd0);
    check("rst evt",  {EVT_VALID, EVT_VOICE, EVT_ON, DROP}, 64'd0);
    RESET = 1'b0;
    drive(1'b1, 8'h64);
    check("post-rst evt",  64'(EVT_VALID),  64'd0);
    check("post-rst gate", 64'(VOICE_GATE), 64'd0);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 10)      d = 8'h90;
      else if (r < 15) d = 8'h80;
      else if (r < 17) d = 8'h91;
      else if (r < 19) d = 8'hB0;
      else if (r < 22) d = 8'(8'hF8 + $urandom_range(0, 7));
      else if (r < 24) d = 8'($urandom_range(0, 127));
      else if (r < 38) d = 8'h00;
      else             d = 8'(8'h3C + $urandom_range(0, 7));
      ch = ($urandom_range(0, 19) == 0) ? 1 : 0;
      CHANNEL = 4'(ch);
      drive(v, d);
      model_step(v, int'(d), ch);
      compare_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
